keccak_absorb_buf: RTL
======================

# keccak_absorb_buf

Sponge absorb front-end for the SHA-3/SHAKE core. It collects 64-bit message words into one rate-sized block and applies Keccak multi-rate padding with the configured domain byte. It then presents the block to the permutation stage, whose round controller starts on `ini` when a block is accepted. The block sits directly upstream of the Keccak round controller and datapath, and sets the first/last flags that control state clearing and squeeze.

## Interface
- `RATE_WORDS`, default 17: rate in 64-bit lanes (17 = SHA3-256/SHAKE256, 21 = SHAKE128).
- `DOMAIN`, default 8'h06: domain-separation byte (8'h06 SHA-3, 8'h1F SHAKE).
- `clk  in  1`: clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `din  in  64`: message word, little-endian bytes (byte i = `din[8i+7:8i]`).
- `din_valid  in  1`: `din` valid.
- `din_last  in  1`: word is the final word of the message.
- `din_bytes  in  4`: valid bytes in the final word, 0..8; values >8 are treated as 8; ignored when `din_last`=0.
- `din_ready  out  1`: word is accepted on a cycle where `din_valid & din_ready`.
- `blk_data  out  64*RATE_WORDS`: padded block; lane k = `blk_data[64k+63:64k]`.
- `blk_valid  out  1`: block presented.
- `blk_first  out  1`: block is the first block of a message; permutation state is cleared before XOR.
- `blk_last  out  1`: block is the final block; squeeze follows.
- `blk_ready  in  1`: permutation accepts; handshake on `blk_valid & blk_ready`. The upstream side of the controller drives `ini` from this handshake.

## Operation
- States:
  - FILL: `din_ready`=1, `blk_valid`=0.
  - OUT: `din_ready`=0, `blk_valid`=1.
- Lane pointer `wptr` runs 0..RATE_WORDS-1. Flag `pad_pend` marks a pending pad-only block. Flag `first_q` marks the next block as first.
- Accepted non-last word:
  - Stored at lane `wptr`, then `wptr`++.
  - If `wptr` was RATE_WORDS-1: go to OUT with `blk_last`=0.
- Accepted last word with n = `din_bytes` < 8:
  - Bytes n..7 of the lane are zeroed.
  - `DOMAIN` is placed at byte n of lane `wptr`.
  - Byte 7 of lane RATE_WORDS-1 is ORed with 8'h80. If it is the same byte as the domain byte, the result is `DOMAIN|8'h80` (8'h86 for SHA-3).
  - Go to OUT with `blk_last`=1.
- Accepted last word with n = 8 and `wptr` < RATE_WORDS-1:
  - `DOMAIN` is placed at byte 0 of lane `wptr`+1.
  - 8'h80 is ORed into the final byte of the block.
  - Go to OUT with `blk_last`=1.
- Accepted last word with n = 8 and `wptr` = RATE_WORDS-1:
  - Go to OUT with `blk_last`=0 and set `pad_pend`.
  - On the handshake, build a pad-only block: lane 0 = `DOMAIN`, final byte 8'h80, all else 0.
  - Stay in OUT with `blk_last`=1 and clear `pad_pend`.
- Lanes beyond the message are zero. The buffer is cleared and `wptr`=0 on every handshake that returns to FILL.
- `blk_first` = `first_q`. `first_q` is set by reset and by a handshake with `blk_last`=1, and cleared by any other handshake.
- The empty message (`din_last`=1, n=0, `wptr`=0) produces a single padding block.

## Timing
- `rst` high: state=FILL, `wptr`=0, buffer=0, `pad_pend`=0, `first_q`=1.
  - Outputs during reset: `din_ready`=0, `blk_valid`=0, `blk_first`=1, `blk_last`=0, `blk_data`=0.
  - `din_ready`=1 in the first cycle after `rst` falls.
- Reset mid-fill or mid-OUT discards the partial block and any pending pad block.
- `blk_valid` asserts the cycle after the completing word is accepted.
- `blk_data`, `blk_first` and `blk_last` are registered. They are stable while `blk_valid`=1 and `blk_ready`=0.
- Handshake cycle N: in cycle N+1 the block is either back in FILL with `din_ready`=1, or holds the pad block with `blk_valid`=1.
- Minimum block period is RATE_WORDS+1 cycles. No word is accepted in the handshake cycle.
- `din_bytes`/`din_last` are sampled only on accept. A `din_valid` drop is legal between words.

## Test plan
- Empty message (`din_last`=1, `din_bytes`=0) -> one block: lane0=64'h06, lane16=64'h8000000000000000, other lanes 0, first=1, last=1.
- "abc": `din`=64'h636261, `din_bytes`=3, last -> lane0=64'h0000000006636261, lane16=64'h80<<56, first=1, last=1.
- 135 bytes (16 full words + last word with `din_bytes`=7, data 0x11..) -> single block, lane16 = 64'h8611111111111111.
- 136 bytes (17 full words, last with `din_bytes`=8) -> block 1 first=1/last=0 holding data; block 2 first=0/last=1, lane0=64'h06, lane16=64'h80<<56, others 0.
- Backpressure: `blk_ready`=0 for 10 cycles -> `blk_valid`=1 and `blk_data` unchanged, `din_ready`=0; handshake then gives `din_ready`=1 next cycle.
- Reset after 5 words, then "abc" -> block identical to the "abc" case (no residue), first=1.

Source files
------------

// File: rtl/keccak_absorb_buf.sv
// keccak_absorb_buf: sponge absorb front-end for the SHA-3/SHAKE core.
// Collects 64-bit message words into one rate-sized block and applies Keccak
// multi-rate padding (domain byte + final 0x80). The finished block is then
// presented to the permutation stage with first/last flags.
module keccak_absorb_buf #(
  parameter int         RATE_WORDS = 17,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [63:0]               din,
  input  logic                      din_valid,
  input  logic                      din_last,
  input  logic [3:0]                din_bytes,
  output logic                      din_ready,
  output logic [64*RATE_WORDS-1:0]  blk_data,
  output logic                      blk_valid,
  output logic                      blk_first,
  output logic                      blk_last,
  input  logic                      blk_ready
);

  localparam int WPW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [WPW-1:0] LAST_LANE = WPW'(RATE_WORDS - 1);

  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t                     state_reg;
  logic [WPW-1:0]             wptr_reg;
  logic                       pad_pend_reg;
  logic                       first_q_reg;
  logic                       last_reg;
  logic [64*RATE_WORDS-1:0]   buf_reg;
  logic [64*RATE_WORDS-1:0]   buf_next;

  logic                       accept;
  logic                       handshake;
  logic                       at_end;
  logic                       full_last;
  logic [3:0]                 nbytes;
  logic [WPW-1:0]             wptr_inc;
  logic [63:0]                last_word;

  assign accept    = (state_reg == FILL) && din_valid;
  assign handshake = (state_reg == OUT) && blk_ready;
  assign at_end    = (wptr_reg == LAST_LANE);
  assign nbytes    = (din_bytes > 4'd8) ? 4'd8 : din_bytes;
  assign full_last = (nbytes == 4'd8);
  assign wptr_inc  = wptr_reg + WPW'(1);

  // Final word: keep bytes below n, zero the rest, drop the domain byte at n.
  always_comb begin
    last_word = din;
    for (int b = 0; b < 8; b++) begin
      if (b >= int'(nbytes)) last_word[8*b +: 8] = 8'h00;
      if (b == int'(nbytes)) last_word[8*b +: 8] = DOMAIN;
    end
  end

  // Per-lane next value. A full last word in the final lane defers the
  // padding to a separate pad-only block built on the following handshake.
  for (genvar gi = 0; gi < RATE_WORDS; gi++) begin : g_lane
    localparam logic [WPW-1:0] LANE = WPW'(gi);
    logic [63:0] lane_next;

    // Select cleared/pad lane on handshake, or write/pad the lane on accept.
    always_comb begin
      lane_next = buf_reg[64*gi +: 64];
      if (handshake) begin
        lane_next = '0;
        if (pad_pend_reg) begin
          if (gi == 0) lane_next[7:0] = DOMAIN;
          if (gi == RATE_WORDS - 1) lane_next[63:56] = lane_next[63:56] | 8'h80;
        end
      end else if (accept) begin
        if (wptr_reg == LANE) begin
          lane_next = din_last ? last_word : din;
        end else if (din_last && full_last && !at_end && (wptr_inc == LANE)) begin
          lane_next = {56'h0, DOMAIN};
        end
        if (din_last && !(full_last && at_end) && (gi == RATE_WORDS - 1)) begin
          lane_next[63:56] = lane_next[63:56] | 8'h80;
        end
      end
    end

    assign buf_next[64*gi +: 64] = lane_next;
  end

  // Block buffer register; it doubles as the registered blk_data output.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg <= '0;
    end else begin
      buf_reg <= buf_next;
    end
  end

  // Fill/present control: lane pointer, pad-pending and first/last flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FILL;
      wptr_reg     <= '0;
      pad_pend_reg <= 1'b0;
      first_q_reg  <= 1'b1;
      last_reg     <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (accept) begin
            if (din_last) begin
              state_reg <= OUT;
              if (full_last && at_end) begin
                pad_pend_reg <= 1'b1;
                last_reg     <= 1'b0;
              end else begin
                last_reg <= 1'b1;
              end
            end else if (at_end) begin
              state_reg <= OUT;
              last_reg  <= 1'b0;
            end else begin
              wptr_reg <= wptr_inc;
            end
          end
        end
        OUT: begin
          if (blk_ready) begin
            first_q_reg <= last_reg;
            if (pad_pend_reg) begin
              pad_pend_reg <= 1'b0;
              last_reg     <= 1'b1;
            end else begin
              state_reg <= FILL;
              wptr_reg  <= '0;
              last_reg  <= 1'b0;
            end
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  assign din_ready = (state_reg == FILL) && !rst;
  assign blk_valid = (state_reg == OUT) && !rst;
  assign blk_first = first_q_reg;
  assign blk_last  = last_reg;
  assign blk_data  = buf_reg;

endmodule
